// File: rtl/addsub_seq_pkg.sv
// Shared definitions for the addsub_seq sequencer: opcodes, FSM state encoding
// and the default operand width.
package addsub_seq_pkg;

  localparam int DEF_W = 32;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_EXEC     = 2'b01,
    ST_MUL_ITER = 2'b10,
    ST_DONE     = 2'b11
  } state_e;

endpackage

// File: rtl/addsub_seq_addsub32.sv
// Combinational W-bit ripple adder-subtractor: F = A + (B ^ {W{S}}) + S.
// With S=1 this is A - B and Cout=1 means no borrow.
module addsub32
  import addsub_seq_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         S,
  output logic [W-1:0] F,
  output logic         Cout
);

  logic carry;
  logic bx;

  // One full adder per bit; the carry ripples LSB to MSB.
  always_comb begin
    F     = '0;
    carry = S;
    bx    = 1'b0;
    for (int i = 0; i < W; i++) begin
      bx    = B[i] ^ S;
      F[i]  = A[i] ^ bx ^ carry;
      carry = (A[i] & bx) | (carry & (A[i] ^ bx));
    end
    Cout = carry;
  end

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle ADD/SUB/MUL sequencer sharing one ripple adder-subtractor.
// Build option: define ADDSUB_SEQ_MUL_EN to compile the shift-and-add multiplier.
module addsub_seq
  import addsub_seq_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] F,
  output logic [W-1:0] F_hi,
  output logic         C,
  output logic         err
);

  state_e state_q, state_d;

  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic         s_q, s_d;

  logic [W-1:0] f_q, f_d;
  logic         c_q, c_d;
  logic         err_q, err_d;

`ifdef ADDSUB_SEQ_MUL_EN
  localparam int CNT_W = $clog2(W);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     acc_hi_q, acc_hi_d;
  logic [W-1:0]     acc_lo_q, acc_lo_d;
  logic [W-1:0]     fhi_q, fhi_d;
`endif

  logic [W-1:0] add_a, add_b, add_f;
  logic         add_s, add_co;

  addsub32 #(.W(W)) u_addsub (
    .A    (add_a),
    .B    (add_b),
    .S    (add_s),
    .F    (add_f),
    .Cout (add_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    f_d     = f_q;
    c_d     = c_q;
    err_d   = err_q;
    add_a   = a_q;
    add_b   = b_q;
    add_s   = s_q;
`ifdef ADDSUB_SEQ_MUL_EN
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    fhi_d    = fhi_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d   = A;
          b_d   = B;
          s_d   = op[0];
          // Clear the result bank so fields an op does not produce read 0.
          f_d   = '0;
          c_d   = 1'b0;
          err_d = 1'b0;
`ifdef ADDSUB_SEQ_MUL_EN
          fhi_d = '0;
`endif
          case (op)
            OP_ADD, OP_SUB: state_d = ST_EXEC;
`ifdef ADDSUB_SEQ_MUL_EN
            OP_MUL: begin
              state_d  = ST_MUL_ITER;
              cnt_d    = CNT_W'(W - 1);
              acc_hi_d = '0;
              acc_lo_d = B;
            end
`endif
            default: begin
              state_d = ST_DONE;
              err_d   = 1'b1;
            end
          endcase
        end
      end

      ST_EXEC: begin
        f_d     = add_f;
        c_d     = add_co;
        state_d = ST_DONE;
      end

`ifdef ADDSUB_SEQ_MUL_EN
      ST_MUL_ITER: begin
        add_a    = acc_hi_q;
        add_b    = acc_lo_q[0] ? a_q : '0;
        add_s    = 1'b0;
        acc_hi_d = {add_co, add_f[W-1:1]};
        acc_lo_d = {add_f[0], acc_lo_q[W-1:1]};
        if (cnt_q == '0) begin
          f_d     = acc_lo_d;
          fhi_d   = acc_hi_d;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif

      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Control and visible result registers: cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      f_q     <= '0;
      c_q     <= 1'b0;
      err_q   <= 1'b0;
`ifdef ADDSUB_SEQ_MUL_EN
      fhi_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      c_q     <= c_d;
      err_q   <= err_d;
`ifdef ADDSUB_SEQ_MUL_EN
      fhi_q   <= fhi_d;
`endif
    end
  end

  // Operand and working registers: only meaningful after an accept.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
    s_q <= s_d;
`ifdef ADDSUB_SEQ_MUL_EN
    cnt_q    <= cnt_d;
    acc_hi_q <= acc_hi_d;
    acc_lo_q <= acc_lo_d;
`endif
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign F         = f_q;
  assign C         = c_q;
  assign err       = err_q;
`ifdef ADDSUB_SEQ_MUL_EN
  assign F_hi      = fhi_q;
`else
  assign F_hi      = '0;
`endif

endmodule

// File: doc/addsub_seq.md
# addsub_seq

Multi-cycle sequencer that time-shares one 32-bit ripple adder-subtractor across three operations: ADD, SUB and unsigned MUL. MUL is shift-and-add, one adder pass per multiplier bit. The block sits between an instruction/issue stage and the arithmetic datapath. Each operation uses a valid/ready handshake on input and output, and only one operation is in flight at a time.

## Interface
- W, 32, operand width; also the MUL iteration count
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operation request
- in_ready  out  1  block can accept; high only in IDLE
- op  in  2  00 ADD, 01 SUB, 10 MUL, 11 reserved
- A  in  W  operand A (multiplicand for MUL)
- B  in  W  operand B (multiplier for MUL)
- out_valid  out  1  result valid; high only in DONE
- out_ready  in  1  consumer takes result
- F  out  W  result; low word for MUL
- F_hi  out  W  MUL high word; 0 for ADD/SUB
- C  out  1  adder carry-out; 0 for MUL and err
- err  out  1  reserved or disabled opcode

## Operation
- States: IDLE, EXEC, MUL_ITER, DONE.
- IDLE
  - in_ready=1.
  - On in_valid & in_ready, capture op, A and B.
  - op ADD or SUB goes to EXEC. op MUL goes to MUL_ITER with cnt=W-1, acc_hi=0, acc_lo=B. op 11 goes to DONE with F=0, err=1.
- EXEC: adder driven with A, B and S=op[0]. Register F and C (C = raw carry-out, so SUB C=1 means no borrow). Then go to DONE.
- MUL_ITER, one cycle per iteration:
  - adder input A=acc_hi, B = acc_lo[0] ? multiplicand : 0, S=0.
  - {acc_hi, acc_lo} <= {carry, sum, acc_lo[W-1:1]}.
  - When cnt==0, go to DONE with F=acc_lo, F_hi=acc_hi. Otherwise cnt decrements.
- DONE: out_valid=1, result registers held stable. On out_ready, go to IDLE.
- Arithmetic: all results modulo 2^W for F. MUL gives the full 2W-bit unsigned product.
- in_valid outside IDLE is ignored, not queued. op, A and B are sampled only at the accept edge.
- Reset (any state, any time):
  - state=IDLE.
  - out_valid, F, F_hi, C and err = 0.
  - in_ready reads 1, but no capture while rst high.
  - An in-flight operation is discarded with no output.

## Timing
- Accept edge = k.
- ADD/SUB: EXEC during cycle k+1; out_valid from cycle k+2.
- MUL: MUL_ITER during cycles k+1..k+W; out_valid from k+W+1 (cycle 33 for W=32).
- err: out_valid from k+1.
- Output handshake edge m returns to IDLE; in_ready=1 from cycle m+1. There is no same-cycle accept-on-release, so the minimum back-to-back ADD period is 3 cycles.
- out_ready held low: DONE persists indefinitely, outputs unchanged.

## Configuration
- ADDSUB_SEQ_MUL_EN
  - Defined: MUL supported as above.
  - Undefined: MUL_ITER, the counter and the accumulator are not compiled. op 10 is handled like op 11 (err=1, F=0, out_valid at k+1), and F_hi is tied to 0.

## Structure
- Shared package holds:
  - opcode constants OP_ADD, OP_SUB, OP_MUL, OP_RSVD
  - state encoding
  - default width 32
- One sub-module, addsub32: the combinational W-bit adder-subtractor built from full adders (ports A, B, S, F, Cout). It is instantiated once and muxed by state.

## Test plan
- ADD A=0xFFFFFFFF, B=1 -> F=0x00000000, C=1, err=0, out_valid exactly 2 cycles after accept.
- SUB 5-7 -> F=0xFFFFFFFE, C=0; SUB 7-5 -> F=0x00000002, C=1.
- MUL 0xFFFFFFFF×0xFFFFFFFF -> F_hi=0xFFFFFFFE, F=0x00000001, out_valid 33 cycles after accept. MUL 0×0x1234 -> both words 0.
- out_ready low 5 cycles in DONE -> F/F_hi/C stable, in_ready=0, a concurrent in_valid is not accepted. Result is released on the first out_ready cycle, and in_ready=1 the next cycle.
- rst pulsed during MUL iteration 10 -> out_valid/F/F_hi/C/err=0 immediately (asynchronous). After release, a fresh ADD 3+4 gives F=7.
- op=11 -> err=1, F=0, out_valid 1 cycle after accept. With ADDSUB_SEQ_MUL_EN undefined, op=10 gives the same response.
